ifetch_unit: RTL and testbench
==============================

# ifetch_unit

Instruction fetch stage for the RV32I core; sits directly upstream of `icache` and drives its CPU-side request port. Maintains the PC, issues one read at a time to the cache, waits for `data_ready`, and buffers returned instructions in a 2-entry FIFO toward decode with a valid/ready handshake. Handles branch/jump redirects, including discarding a cache response that is already in flight.

## Interface
- `RESET_PC`, 16'h0000, PC loaded on reset; bits [1:0] forced to 0.
- `ADDR_W`, 16, cache address width; must match `icache` `address`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ic_address`  out  ADDR_W  fetch address to `icache.address`; registered.
- `ic_rd`  out  1  read request to `icache.rd`; registered.
- `ic_wr`  out  4  to `icache.wr`; constant 4'b0000.
- `ic_data_in`  out  32  to `icache.data_in_cpu`; constant 0.
- `ic_data`  in  32  `icache.data2cpu`; valid in the cycle `ic_data_ready`=1.
- `ic_hit_miss`  in  1  `icache.hit_miss`; 1 = hit, sampled with `ic_data_ready`.
- `ic_data_ready`  in  1  `icache.data_ready`; one-cycle response strobe.
- `redirect_valid`  in  1  one-cycle pulse: change fetch stream.
- `redirect_pc`  in  ADDR_W  new target; bits [1:0] ignored.
- `inst_valid`  out  1  FIFO head valid.
- `inst_ready`  in  1  decode accepts head when `inst_valid & inst_ready`.
- `inst`  out  32  head instruction word.
- `inst_pc`  out  ADDR_W  address the head word was fetched from.
- `perf_fetch_cnt`  out  32  see Configuration.
- `perf_miss_cnt`  out  32  see Configuration.

## Operation
- States: GAP, REQ, DRAIN, HOLD.
- GAP: `ic_rd`=0 for one cycle. Next: REQ if FIFO count ≤1, else HOLD.
- HOLD: `ic_rd`=0; FIFO full. Go to GAP when count drops below 2.
- REQ: `ic_rd`=1, `ic_address`=pc held stable until `ic_data_ready`. On `ic_data_ready`: push {pc, `ic_data`} into FIFO, pc ← pc+4, go to GAP.
- DRAIN: `ic_rd`=1 held on the stale address (cache transaction cannot be cancelled); on `ic_data_ready` drop the word, do not advance pc, go to GAP.
- Redirect (`redirect_valid`=1): FIFO flushed (count ← 0, `inst_valid` ← 0 next cycle); pc ← {`redirect_pc`[15:2],2'b00}. From REQ without `ic_data_ready` → DRAIN; from REQ with `ic_data_ready` same cycle → response dropped, → GAP; from DRAIN → stay DRAIN, target updated (last redirect wins); from GAP/HOLD → GAP.
- FIFO: 2 entries, in-order; push and pop in the same cycle permitted; push occurs only when count ≤1 at request issue, so overflow is impossible. Pop on flush is ignored.
- PC arithmetic modulo 2^ADDR_W: 16'hFFFC + 4 → 16'h0000.
- Only one cache transaction outstanding at any time.

## Timing
- Reset values: `ic_rd`=0, `ic_address`=RESET_PC, `inst_valid`=0, `inst`=0, `inst_pc`=0, FIFO count=0, state=GAP, perf counters=0.
- First `ic_rd`=1 in the second cycle after `rst` deasserts.
- Cache response in cycle N → `inst_valid`=1 in cycle N+1; `ic_rd` low in N+1 (GAP), next request raised in N+2.
- Throughput on back-to-back hits is bounded by cache latency plus one GAP cycle.
- Redirect in cycle N → FIFO empty in N+1; the first request to the new target is raised no earlier than N+2, and after the drained response if one was in flight.
- `rst` mid-transaction: all state reset; the in-flight cache request is abandoned (the cache shares `rst`).

## Configuration
- `IF_PERF_EN` defined: `perf_fetch_cnt` increments on every FIFO push; `perf_miss_cnt` increments on every accepted (non-dropped) response with `ic_hit_miss`=0. Both saturate at 32'hFFFFFFFF and clear on `rst`.
- Not defined: both outputs tied to 32'h0; no counter flops synthesized.

## Test plan
- Reset with RESET_PC=16'h0404, memory at 0x0404=32'hDEADBEEF, `inst_ready`=1 → `ic_rd` rises with `ic_address`=16'h0404 two cycles after reset; `inst`=32'hDEADBEEF, `inst_pc`=16'h0404 one cycle after `ic_data_ready`.
- Sequential fetch from 0x0000 with `inst_ready`=1 → `inst_pc` sequence 0x0000, 0x0004, 0x0008; second pass over the same lines shows `ic_hit_miss`=1, and with `IF_PERF_EN` `perf_miss_cnt` stops incrementing.
- `inst_ready`=0 → exactly 2 words buffered, then state HOLD with `ic_rd`=0; raise `inst_ready` → words drain in order and fetching resumes at pc+8.
- `redirect_valid` with `redirect_pc`=16'h2407 while a miss to 0x1404 is in flight → 0x1404 word never appears on `inst`; next request is to 0x2404.
- `redirect_valid` coincident with `ic_data_ready` → returned word dropped, FIFO empty next cycle, next request to the redirect target.
- PC at 16'hFFFC → next fetch address 16'h0000; `rst` asserted while `ic_rd`=1 → `ic_rd`=0 and `inst_valid`=0 in the following cycle.

Source files
------------

// File: rtl/ifetch_unit.sv
`timescale 1ns/1ps
// ifetch_unit: RV32I fetch stage driving the icache CPU port, buffering words in a 2-entry FIFO.
// Define IF_PERF_EN to build the saturating fetch/miss performance counters.
module ifetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] ic_address,
  output logic              ic_rd,
  output logic [3:0]        ic_wr,
  output logic [31:0]       ic_data_in,
  input  logic [31:0]       ic_data,
  input  logic              ic_hit_miss,
  input  logic              ic_data_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_miss_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {GAP = 2'd0, REQ = 2'd1, DRAIN = 2'd2, HOLD = 2'd3} state_e;

  localparam logic [ADDR_W-1:0] PC_INIT = {RESET_PC[ADDR_W-1:2], 2'b00};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic [31:0]       fifo_data_q [2];
  logic [31:0]       fifo_data_d [2];
  logic [ADDR_W-1:0] fifo_pc_q [2];
  logic [ADDR_W-1:0] fifo_pc_d [2];
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push, pop;
  logic [ADDR_W-1:0] target_pc;
  logic [1:0]        unused_redirect_lo;

  assign unused_redirect_lo = redirect_pc[1:0];
  assign target_pc          = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Decode handshake: the head word transfers when inst_valid & inst_ready are both
  // high at a rising edge; a redirect in that cycle flushes instead of transferring.
  assign inst_valid = (count_q != 2'd0);
  assign inst       = fifo_data_q[rd_ptr_q];
  assign inst_pc    = fifo_pc_q[rd_ptr_q];
  assign pop        = inst_valid && inst_ready && !redirect_valid;

  assign ic_address = addr_q;
  assign ic_rd      = rd_q;
  assign ic_wr      = 4'b0000;
  assign ic_data_in = 32'h0;
  assign dbg_state  = state_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    case (state_q)
      GAP: begin
        if (redirect_valid)       state_d = GAP;
        else if (count_q <= 2'd1) state_d = REQ;
        else                      state_d = HOLD;
      end
      HOLD: begin
        if (redirect_valid || count_q < 2'd2) state_d = GAP;
      end
      REQ: begin
        if (redirect_valid) begin
          state_d = ic_data_ready ? GAP : DRAIN;
        end else if (ic_data_ready) begin
          push    = 1'b1;
          pc_d    = pc_q + ADDR_W'(4);
          state_d = GAP;
        end
      end
      DRAIN: begin
        // The stale response is consumed and discarded; pc already holds the target.
        if (ic_data_ready) state_d = GAP;
      end
      default: state_d = GAP;
    endcase
    if (redirect_valid) pc_d = target_pc;

    rd_d   = (state_d == REQ) || (state_d == DRAIN);
    addr_d = (state_d == DRAIN) ? addr_q : pc_d;
  end

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (redirect_valid) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (push) begin
        fifo_data_d[wr_ptr_q] = ic_data;
        fifo_pc_d[wr_ptr_q]   = pc_q;
        wr_ptr_d              = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= GAP;
      pc_q     <= PC_INIT;
      addr_q   <= PC_INIT;
      rd_q     <= 1'b0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data_q[i] <= 32'h0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

`ifdef IF_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d, miss_cnt_q, miss_cnt_d;

  // Both counters stick at all-ones instead of wrapping.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (push && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (push && !ic_hit_miss && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      miss_cnt_q  <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_miss_cnt  = miss_cnt_q;
`else
  logic unused_hit_miss;
  assign unused_hit_miss = ic_hit_miss;
  assign perf_fetch_cnt  = 32'h0;
  assign perf_miss_cnt   = 32'h0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
`timescale 1ns/1ps
// tb_ifetch_unit: randomized fetch stream against a behavioural cache and fetch-stream model.
module tb_ifetch_unit;
  localparam int          ADDR_W   = 16;
  localparam logic [15:0] RESET_PC = 16'h0404;
  localparam logic [1:0]  ST_GAP   = 2'd0;
  localparam logic [1:0]  ST_HOLD  = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ic_address;
  logic        ic_rd;
  logic [3:0]  ic_wr;
  logic [31:0] ic_data_in;
  logic [31:0] ic_data;
  logic        ic_hit_miss;
  logic        ic_data_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [15:0] inst_pc;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_miss_cnt;
  logic [1:0]  dbg_state;

  ifetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .ic_address(ic_address), .ic_rd(ic_rd), .ic_wr(ic_wr), .ic_data_in(ic_data_in),
    .ic_data(ic_data), .ic_hit_miss(ic_hit_miss), .ic_data_ready(ic_data_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_miss_cnt(perf_miss_cnt), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int          check_cnt = 0;
  int          pass_cnt  = 0;
  logic [47:0] exp_q[$];          // {pc, word} expected on the decode port, in order
  logic [15:0] exp_pc;            // next address the fetch stream must request
  bit          stale;             // in-flight response that must be discarded
  bit          push_now;          // an entry was queued this cycle (visible next cycle)
  bit          push_miss_now;
  int unsigned m_fetch, m_miss;
  bit          seen[int];         // cache lines already filled
  bit          busy;
  int          cnt;
  int          fix_lat = -1;
  logic [15:0] req_addr;
  bit          req_hit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic timeout(input string name);
    check_cnt++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    if (a == 16'h0404) return 32'hDEADBEEF;
    return {a ^ 16'hA5C3, a};
  endfunction

  // ---------------- cache + reference model ----------------
  initial begin
    ic_data_ready = 1'b0;
    ic_data       = 32'h0;
    ic_hit_miss   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      push_now      = 1'b0;
      push_miss_now = 1'b0;
      ic_data_ready = 1'b0;
      ic_data       = $urandom;
      if (rst) begin
        busy    = 1'b0;
        stale   = 1'b0;
        exp_q.delete();
        exp_pc  = {RESET_PC[15:2], 2'b00};
        m_fetch = 0;
        m_miss  = 0;
      end else begin
        bit resp_now;
        resp_now = 1'b0;
        if (!busy && ic_rd) begin
          check("req_addr", 32'(ic_address), 32'(exp_pc));
          busy     = 1'b1;
          req_addr = ic_address;
          req_hit  = seen.exists(int'(ic_address[15:4]));
          if (fix_lat >= 0) cnt = fix_lat;
          else cnt = req_hit ? $urandom_range(0, 1) : $urandom_range(2, 4);
        end
        if (busy) begin
          check("req_stable", 32'({ic_rd, ic_address}), 32'({1'b1, req_addr}));
          if (cnt == 0) begin
            ic_data_ready = 1'b1;
            ic_data       = mem_word(req_addr);
            ic_hit_miss   = req_hit;
            seen[int'(req_addr[15:4])] = 1'b1;
            busy     = 1'b0;
            resp_now = 1'b1;
          end else begin
            cnt--;
          end
        end
        if (redirect_valid) begin
          exp_q.delete();
          exp_pc = {redirect_pc[15:2], 2'b00};
          stale  = busy;
        end else if (resp_now) begin
          if (stale) begin
            stale = 1'b0;
          end else begin
            exp_q.push_back({req_addr, mem_word(req_addr)});
            push_now = 1'b1;
            exp_pc   = exp_pc + 16'd4;
            m_fetch++;
            if (!req_hit) begin
              m_miss++;
              push_miss_now = 1'b1;
            end
          end
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        int vis;
        logic [47:0] e;
        vis = exp_q.size() - (push_now ? 1 : 0);
        check("ic_wr", 32'(ic_wr), 32'h0);
        check("ic_data_in", ic_data_in, 32'h0);
`ifdef IF_PERF_EN
        check("perf_fetch", perf_fetch_cnt, m_fetch - (push_now ? 1 : 0));
        check("perf_miss", perf_miss_cnt, m_miss - (push_miss_now ? 1 : 0));
`else
        check("perf_fetch", perf_fetch_cnt, 32'h0);
        check("perf_miss", perf_miss_cnt, 32'h0);
`endif
        if (!redirect_valid) begin
          check("inst_valid", 32'(inst_valid), 32'(vis > 0));
          if (vis == 2) check("full_no_req", 32'(ic_rd), 32'h0);
          if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
              check_cnt++;
              $display("FAIL unexpected_inst: got pc %h word %h, expected none", inst_pc, inst);
            end else begin
              e = exp_q.pop_front();
              check("inst_pc", 32'(inst_pc), 32'(e[47:32]));
              check("inst", inst, e[31:0]);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic redirect(input logic [15:0] t);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = t;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  // Returns #1 after the edge of the first cycle a request to a is presented.
  task automatic wait_req(input logic [15:0] a);
    for (int i = 0; i < 500; i++) begin
      if (ic_rd && ic_address == a) return;
      @(posedge clk); #1;
    end
    timeout("wait_req");
  endtask

  task automatic wait_rd_rise();
    for (int i = 0; i < 500 && ic_rd; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 500; i++) begin
      if (ic_rd) return;
      @(posedge clk); #1;
    end
    timeout("wait_rd_rise");
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ic_data_ready) return;
    end
    timeout("wait_ready");
  endtask

  task automatic wait_rd_neg();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (ic_rd) return;
    end
    timeout("wait_rd_neg");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst            = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("rst_ic_rd", 32'(ic_rd), 32'h0);
    check("rst_addr", 32'(ic_address), 32'h0404);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", 32'(inst_pc), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(ST_GAP));
    check("rst_perf_fetch", perf_fetch_cnt, 32'h0);
    check("rst_perf_miss", perf_miss_cnt, 32'h0);
    @(negedge clk);
    check("first_rd", 32'(ic_rd), 32'h1);
    check("first_addr", 32'(ic_address), 32'h0404);
    wait_ready();
    @(negedge clk);
    check("boot_valid", 32'(inst_valid), 32'h1);
    check("boot_inst", inst, 32'hDEADBEEF);
    check("boot_pc", 32'(inst_pc), 32'h0404);

    // sequential stream from 0, then the same lines again as hits
    redirect(16'h0000);
    run(40);
    redirect(16'h0000);
    run(40);

    // decode stalls: FIFO fills, fetch holds, then drains in order
    @(posedge clk); #1 inst_ready = 1'b0;
    run(40);
    @(negedge clk);
    check("hold_state", 32'(dbg_state), 32'(ST_HOLD));
    check("hold_rd", 32'(ic_rd), 32'h0);
    check("hold_valid", 32'(inst_valid), 32'h1);
    @(posedge clk); #1 inst_ready = 1'b1;
    run(30);

    // redirect while a miss is in flight
    redirect(16'h1404);
    wait_req(16'h1404);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h2407;
    @(posedge clk); #1 redirect_valid = 1'b0;
    wait_ready();
    wait_rd_neg();
    check("drain_next_addr", 32'(ic_address), 32'h2404);
    wait_ready();
    @(negedge clk);
    check("drain_first_valid", 32'(inst_valid), 32'h1);
    check("drain_first_pc", 32'(inst_pc), 32'h2404);

    // redirect coincident with the response
    @(posedge clk); #1 fix_lat = 0;
    wait_rd_rise();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h4101;
    @(posedge clk); #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("coinc_empty", 32'(inst_valid), 32'h0);
    wait_rd_neg();
    check("coinc_next_addr", 32'(ic_address), 32'h4100);
    fix_lat = -1;
    run(20);

    // pc wraps modulo 2^16
    redirect(16'hFFF8);
    wait_req(16'hFFFC);
    wait_ready();
    wait_rd_neg();
    check("wrap_addr", 32'(ic_address), 32'h0000);
    run(20);

    // reset while a request is outstanding
    wait_rd_rise();
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rd", 32'(ic_rd), 32'h0);
    check("mid_rst_valid", 32'(inst_valid), 32'h0);
    check("mid_rst_addr", 32'(ic_address), 32'h0404);

    // randomized back-pressure and redirects
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 7) == 0) redirect_pc = 16'($urandom_range(16'hFFE0, 16'hFFFF));
      else redirect_pc = 16'($urandom_range(0, 16'h03FF));
    end
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    run(40);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
